ps2_scan_decode_module: RTL and testbench
=========================================

# ps2_scan_decode_module

Parametrised PS/2 keyboard frame receiver and scan-code decoder. Samples PS2_DAT on PS/2 clock falling edges flagged by the upstream edge detector (isH2L). Checks start, odd-parity and stop bits, recovers from stalled frames with a timeout, and folds E0/F0 prefixes into flags on each event. Decoded events go into a first-word-fall-through FIFO with a valid/read handshake; oTrig is kept as a per-event strobe for existing consumers.

## Interface
- TIMEOUT_CYC, 50000: CLOCK cycles without isH2L inside a frame before the frame is aborted (1 ms at 50 MHz).
- FIFO_AW, 2: FIFO address width; depth = 2**FIFO_AW events.
- PARITY_CHECK, 1: 1 = reject frames with bad odd parity; 0 = ignore the parity bit.
- CLOCK  in  1  system clock.
- RST_n  in  1  reset, asynchronous, active-low.
- isH2L  in  1  one-cycle pulse per PS/2 clock falling edge, synchronous to CLOCK.
- PS2_DAT  in  1  synchronised PS/2 data line.
- iRead  in  1  pop the head event; ignored when oValid=0.
- oValid  out  1  FIFO not empty.
- oData  out  8  head event scan code.
- oBreak  out  1  head event was preceded by F0 (key release).
- oExt  out  1  head event was preceded by E0 (extended key).
- oTrig  out  1  one-cycle pulse when an event is written to the FIFO.
- oErr  out  1  one-cycle pulse on a rejected frame (start, parity, stop or timeout).
- oDrop  out  1  one-cycle pulse when an event is lost because the FIFO is full.

## Operation
- Frame FSM. All states except TIMEOUT handling advance only on isH2L.
  - IDLE: on isH2L, if PS2_DAT=0, go to DATA. If PS2_DAT=1 (spurious edge), stay in IDLE with no error.
  - DATA: 8 samples, LSB first, into the shift register; a 3-bit counter selects the bit.
  - PARITY: store the parity bit.
  - STOP: the frame is good when PS2_DAT=1 and, if PARITY_CHECK=1, the XOR of the 8 data bits and the parity bit equals 1.
  - STOP always returns to IDLE.
- Timeout:
  - The counter clears on every isH2L and counts while the FSM is not in IDLE.
  - When it reaches TIMEOUT_CYC-1: FSM returns to IDLE, oErr pulses, and both prefix flags clear.
  - The counter width is $clog2(TIMEOUT_CYC)+1.
- Prefix decoder, acting on good bytes:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte writes {ext_pend, brk_pend, byte} to the FIFO, pulses oTrig, then clears both flags.
  - Prefixes never produce an event.
- Bad frames: discard the byte, pulse oErr, clear both prefix flags.
- FIFO:
  - 10-bit entries; write/read pointers of FIFO_AW bits; count of FIFO_AW+1 bits; wrap-around is natural.
  - oData/oBreak/oExt show the head entry combinationally from the array whenever oValid=1. When oValid=0 they hold the last popped value (0 after reset).
  - Pop happens when iRead && oValid.
  - Push when full and no pop in the same cycle: the event is discarded, oDrop pulses, oTrig stays 0, and the FIFO is unchanged.
  - Push and pop in the same cycle: both succeed, including when the FIFO is full or when it holds exactly one entry. Count is unchanged.

## Timing
- Reset values: FSM=IDLE, pointers/count=0, flags=0, oValid=0, oData=0, oBreak=0, oExt=0, oTrig=0, oErr=0, oDrop=0.
- Reset asserted mid-frame or with a non-empty FIFO discards everything immediately (asynchronous).
- Write latency:
  - Edge N samples the stop bit; the decoded byte is registered at N.
  - The FIFO write and the oTrig pulse occur at edge N+1; oValid=1 from that point.
  - oErr for a bad stop/parity frame pulses at edge N+1.
- Pop: the head advances on the edge where iRead && oValid. Data is valid the same cycle oValid is high; there is no read latency.
- oTrig, oErr and oDrop are exactly one CLOCK wide and mutually exclusive per frame.
- isH2L while the timeout fires in the same cycle: the timeout wins and the edge is ignored.

## Test plan
- Single make code: frame 0x1C, parity 0, stop 1 -> one oTrig pulse; oValid=1, oData=0x1C, oBreak=0, oExt=0; iRead for 1 cycle -> oValid=0.
- Break sequence: F0 (parity 1) then 1C -> exactly one event, oData=0x1C, oBreak=1, oExt=0; no event for F0.
- Extended release: E0, F0, 75 (parities 0, 1, 0) -> single event 0x75, oExt=1, oBreak=1. A following 0x75 gives oExt=0, oBreak=0.
- Parity error: 0x1C with parity 1 -> oErr pulse, no event, FIFO empty. Repeat with PARITY_CHECK=0 -> event 0x1C delivered.
- Timeout: start bit plus 3 data bits, then no isH2L for TIMEOUT_CYC cycles -> oErr pulse, FSM in IDLE. A following clean 0x1C frame decodes correctly.
- FIFO limits (FIFO_AW=2):
  - 5 events with iRead=0 -> 4 stored; 5th gives oDrop with no oTrig.
  - Drain -> codes come out in order.
  - Then fill to 4 entries, complete a 5th frame with iRead=1 on its write cycle -> oTrig pulses, no oDrop, count stays 4.

Source files
------------

// File: rtl/ps2_scan_decode_module.sv
// ps2_scan_decode_module: PS/2 frame receiver with E0/F0 prefix folding and an event FIFO.
module ps2_scan_decode_module #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_AW = 2,
  parameter bit PARITY_CHECK = 1
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic       isH2L,
  input  logic       PS2_DAT,
  input  logic       iRead,
  output logic       oValid,
  output logic [7:0] oData,
  output logic       oBreak,
  output logic       oExt,
  output logic       oTrig,
  output logic       oErr,
  output logic       oDrop
);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic done_q, done_d, ok_q, ok_d;
  logic ext_q, ext_d, brk_q, brk_d;
  logic trig_q, trig_d, err_q, err_d, drop_q, drop_d;
  logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_AW:0] cnt_q, cnt_d;
  logic [9:0] last_q, last_d;
  logic [9:0] mem_q [DEPTH];
  logic tmo, pop, push_req, push, full, bad;
  always_comb begin
    tmo = (state_q != IDLE) && (tcnt_q == TW'(TIMEOUT_CYC - 1));
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    done_d = 1'b0;
    ok_d = 1'b0;
    tcnt_d = (isH2L || tmo || state_q == IDLE) ? '0 : tcnt_q + 1'b1;
    if (tmo) state_d = IDLE;
    else if (isH2L) begin
      case (state_q)
        IDLE: begin
          state_d = PS2_DAT ? IDLE : DATA;
          bit_d = '0;
        end
        DATA: begin
          sh_d = {PS2_DAT, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          state_d = (bit_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d = PS2_DAT;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          done_d = 1'b1;
          ok_d = PS2_DAT && (!PARITY_CHECK || (^sh_q ^ par_q));
        end
      endcase
    end
  end
  // sh_q stays stable for the cycle after STOP, so the decoder reads it directly
  always_comb begin
    oValid = cnt_q != '0;
    full = cnt_q == (FIFO_AW + 1)'(DEPTH);
    pop = iRead && oValid;
    bad = tmo || (done_q && !ok_q);
    push_req = done_q && ok_q && sh_q != 8'hE0 && sh_q != 8'hF0;
    push = push_req && (!full || pop);
    ext_d = bad ? 1'b0 : done_q ? (sh_q == 8'hE0) || (ext_q && !push_req) : ext_q;
    brk_d = bad ? 1'b0 : done_q ? (sh_q == 8'hF0) || (brk_q && !push_req) : brk_q;
    trig_d = push;
    drop_d = push_req && !push;
    err_d = bad;
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    last_d = pop ? mem_q[rp_q] : last_q;
    {oExt, oBreak, oData} = oValid ? mem_q[rp_q] : last_q;
  end
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      tcnt_q <= '0;
      done_q <= 1'b0;
      ok_q <= 1'b0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      trig_q <= 1'b0;
      err_q <= 1'b0;
      drop_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      tcnt_q <= tcnt_d;
      done_q <= done_d;
      ok_q <= ok_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      trig_q <= trig_d;
      err_q <= err_d;
      drop_q <= drop_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (push) mem_q[wp_q] <= {ext_q, brk_q, sh_q};
  end
  assign oTrig = trig_q;
  assign oErr = err_q;
  assign oDrop = drop_q;
endmodule

// File: tb/tb_ps2_scan_decode_module.sv
// tb_ps2_scan_decode_module: random PS/2 frames scored against a queue-based key event model.
module tb_ps2_scan_decode_module;
  localparam int TO = 64;
  logic clk = 0, rst_n = 0, h2l = 0, dat = 1, rd = 0;
  logic valid, brk, ext, trig, err, drop;
  logic [7:0] data;
  logic np_valid, np_brk, np_ext, np_trig, np_err, np_drop;
  logic [7:0] np_data;
  int n_chk = 0, n_pass = 0;
  logic [9:0] exp_q[$], np_q[$];
  bit ext_m, brk_m, np_ext_m, np_brk_m;
  int exp_trig = 0, exp_err = 0, exp_drop = 0, n_trig = 0, n_err = 0, n_drop = 0;
  bit rd_en = 1, force_rd = 0;

  always #5 clk = ~clk;

  ps2_scan_decode_module #(.TIMEOUT_CYC(TO), .FIFO_AW(2), .PARITY_CHECK(1)) dut (
    .CLOCK(clk), .RST_n(rst_n), .isH2L(h2l), .PS2_DAT(dat), .iRead(rd),
    .oValid(valid), .oData(data), .oBreak(brk), .oExt(ext),
    .oTrig(trig), .oErr(err), .oDrop(drop));

  // parity-blind instance, always drained
  ps2_scan_decode_module #(.TIMEOUT_CYC(TO), .FIFO_AW(2), .PARITY_CHECK(0)) dut_np (
    .CLOCK(clk), .RST_n(rst_n), .isH2L(h2l), .PS2_DAT(dat), .iRead(np_valid),
    .oValid(np_valid), .oData(np_data), .oBreak(np_brk), .oExt(np_ext),
    .oTrig(np_trig), .oErr(np_err), .oDrop(np_drop));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  initial forever begin
    @(negedge clk);
    rd = 0;
    if (rst_n) begin
      if (trig) n_trig++;
      if (err) n_err++;
      if (drop) n_drop++;
      if (valid && (rd_en || force_rd)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: got %0h expected none", {ext, brk, data});
        end else chk("event", {ext, brk, data}, exp_q.pop_front());
        rd = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && np_valid) begin
      if (np_q.size() == 0) begin
        n_chk++;
        $display("FAIL np_unexpected_event: got %0h expected none", {np_ext, np_brk, np_data});
      end else chk("np_event", {np_ext, np_brk, np_data}, np_q.pop_front());
    end
  end

  task automatic model(input logic [7:0] b, input bit pbad, input bit sbad, input bit fr);
    if (pbad || sbad) begin
      ext_m = 0; brk_m = 0; exp_err++;
    end else if (b == 8'hE0) ext_m = 1;
    else if (b == 8'hF0) brk_m = 1;
    else begin
      if (!rd_en && !fr && exp_q.size() >= 4) exp_drop++;
      else begin
        exp_q.push_back({ext_m, brk_m, b});
        exp_trig++;
      end
      ext_m = 0; brk_m = 0;
    end
    if (sbad) begin
      np_ext_m = 0; np_brk_m = 0;
    end else if (b == 8'hE0) np_ext_m = 1;
    else if (b == 8'hF0) np_brk_m = 1;
    else begin
      np_q.push_back({np_ext_m, np_brk_m, b});
      np_ext_m = 0; np_brk_m = 0;
    end
  endtask

  task automatic pulse(input bit d, input bit fr);
    @(posedge clk); #1 dat = d; h2l = 1;
    @(posedge clk); #1 h2l = 0; force_rd = fr;
    if (fr) begin @(posedge clk); #1 force_rd = 0; end
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic check_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("trig_count", n_trig, exp_trig);
    chk("err_count", n_err, exp_err);
    chk("drop_count", n_drop, exp_drop);
  endtask

  task automatic send(input logic [7:0] b, input bit pbad, input bit sbad, input bit fr);
    model(b, pbad, sbad, fr);
    pulse(0, 0);
    for (int i = 0; i < 8; i++) pulse(b[i], 0);
    pulse(~^b ^ pbad, 0);
    pulse(!sbad, fr);
    check_counts();
  endtask

  task automatic timeout(input int k);
    exp_err++;
    ext_m = 0; brk_m = 0; np_ext_m = 0; np_brk_m = 0;
    pulse(0, 0);
    for (int i = 0; i < k; i++) pulse($urandom_range(0, 1) == 1, 0);
    repeat (TO + 5) @(posedge clk);
    check_counts();
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] codes[5];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_head", {ext, brk, data}, 0);
    chk("rst_pulses", {trig, err, drop}, 0);
    rst_n = 1;
    send(8'h1C, 0, 0, 0);
    chk("hold_after_pop", {valid, data}, {1'b0, 8'h1C});
    send(8'hF0, 0, 0, 0); send(8'h1C, 0, 0, 0);
    send(8'hE0, 0, 0, 0); send(8'hF0, 0, 0, 0); send(8'h75, 0, 0, 0);
    send(8'h75, 0, 0, 0);
    send(8'h1C, 1, 0, 0);
    timeout(3);
    send(8'h1C, 0, 0, 0);
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    rd_en = 0;
    for (int i = 0; i < 5; i++) send(codes[i], 0, 0, 0);
    chk("full_head", {valid, ext, brk, data}, {1'b1, 2'b00, 8'h15});
    rd_en = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("drained", {valid, 8'(exp_q.size())}, 0);
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    rd_en = 0;
    for (int i = 0; i < 4; i++) send(codes[i], 0, 0, 0);
    send(codes[4], 0, 0, 1);
    chk("full_popwrite_head", {valid, data}, {1'b1, 8'h1E});
    chk("full_popwrite_depth", exp_q.size(), 4);
    rd_en = 1;
    repeat (10) @(posedge clk);
    rd_en = 0;
    send(8'h1C, 0, 0, 0); send(8'h32, 0, 0, 0);
    pulse(0, 0); pulse(1, 0); pulse(0, 0);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("async_rst_valid", valid, 0);
    chk("async_rst_head", {ext, brk, data}, 0);
    exp_q.delete(); np_q.delete();
    ext_m = 0; brk_m = 0; np_ext_m = 0; np_brk_m = 0;
    @(posedge clk); #1 rst_n = 1; rd_en = 1;
    send(8'h1C, 0, 0, 0);
    for (int it = 0; it < 200; it++) begin
      int op;
      rd_en = $urandom_range(0, 3) != 0;
      op = $urandom_range(0, 99);
      if (op < 8) timeout($urandom_range(0, 9));
      else if (op < 13) begin pulse(1, 0); check_counts(); end
      else begin
        case ($urandom_range(0, 5))
          0: b = 8'hE0;
          1: b = 8'hF0;
          default: b = 8'($urandom_range(0, 255));
        endcase
        send(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
             !rd_en && $urandom_range(0, 3) == 0);
      end
    end
    rd_en = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("final_queue", exp_q.size(), 0);
    chk("final_np_queue", np_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
